sram_arb: RTL and testbench
===========================

Name: sram_arb

Overview:
- Two-requester arbiter and sequencer in front of the single-port 16-bit x 2^19 `sram` macro.
- Accepts read/write requests from port A and port B over valid/ready handshakes and grants them round-robin.
- Drives the SRAM chip-select, write-enable, address and write-data pins from registers.
- Returns read data to the requester that issued the read, tracked through a fixed-latency pipeline.

Parameters:
- AW, 19, SRAM address width.
- DW, 16, SRAM data width.
- RD_LAT, 1, SRAM read latency in cycles; legal range 1..4.
- WR_TURN, 1, idle cycles forced between a read issue and a following write issue (bus turnaround); legal range 0..2.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- a_valid  in  1  port A request valid.
- a_ready  out  1  port A request accepted this cycle.
- a_we  in  1  port A 1=write, 0=read.
- a_addr  in  AW  port A address.
- a_wdata  in  DW  port A write data.
- a_rvalid  out  1  port A read data valid, one-cycle pulse.
- a_rdata  out  DW  port A read data.
- b_valid, b_ready, b_we, b_addr, b_wdata, b_rvalid, b_rdata  same as port A, for port B.
- sram_csn  out  1  SRAM chip select, active low.
- sram_wen  out  1  SRAM write enable, active low.
- sram_a  out  AW  SRAM address.
- sram_din  out  DW  SRAM write data.
- sram_dout  in  DW  SRAM read data.
- idle  out  1  high when no read is in flight and no access was issued in the current cycle.

Behaviour:
- Reset (rstn low, asynchronous):
  - sram_csn=1, sram_wen=1, sram_a=0, sram_din=0.
  - a_rvalid=b_rvalid=0; a_rdata=b_rdata=0.
  - RR pointer=A (A has priority first).
  - Turnaround counter=0; read-tracking pipeline cleared.
  - In-flight reads are discarded and never produce rvalid.
  - Outputs are stable from the first edge after rstn rises.
- Arbitration (combinational, per cycle):
  - Eligible = valid, and not (we=1 while turnaround counter>0).
  - If exactly one port is eligible, it is granted.
  - If both are eligible, the port other than the last-accepted one is granted.
  - x_ready = grant_x.
  - At most one ready is high per cycle.
  - A request is accepted on a rising edge where valid&&ready.
  - The RR pointer updates only on accept.
  - Requesters must hold valid, we, addr and wdata stable until accepted.
- Issue:
  - Accept at edge N: from edge N, sram_csn=0, sram_wen=~we, sram_a=addr, sram_din=wdata, for one cycle.
  - With no accept, sram_csn=1 and sram_wen=1; sram_a and sram_din hold their last values.
  - Back-to-back accepts are allowed: one access per cycle, full throughput.
- Turnaround:
  - A read accept loads the counter with WR_TURN.
  - The counter decrements each cycle to 0.
  - Writes are ineligible while counter>0; reads remain eligible.
  - A write blocked by turnaround does not block the other port's read.
- Read return:
  - The SRAM samples at edge N+1; sram_dout is valid for capture at edge N+1+RD_LAT.
  - The owner tag (A/B) shifts through an RD_LAT+1 deep valid/tag pipeline.
  - At edge N+1+RD_LAT, the owner's rdata<=sram_dout and its rvalid goes high for one cycle.
  - With RD_LAT=1, a read accepted at edge N gives rvalid high from edge N+2 to N+3.
  - Responses return in issue order.
  - Both rvalids are never high together.
  - There is no backpressure on responses.
  - rdata holds its value between pulses.
  - Writes produce no response.
- idle = no pipeline stage valid and sram_csn=1.
- Simultaneous events:
  - A read may be accepted in the same cycle an earlier read returns.
  - When both ports are valid and only one is eligible (e.g. B write in turnaround), the eligible port wins and the RR pointer moves to it.

Test Plan:
- Reset, then A read addr=0x00001 with SRAM preloaded 0xBEEF -> sram_csn=0 and sram_a=0x00001 for 1 cycle after the accept edge; a_rvalid pulse 2 cycles after accept, a_rdata=0xBEEF; b_rvalid stays 0.
- A and B both hold reads (0x00005, 0x00043) valid continuously for 6 cycles -> grants alternate A,B,A,B,A,B; rvalid alternates accordingly with matching data; sram_csn low all 6 issue cycles.
- A write 0x1234 to 0x00005, then B read 0x00005 -> b_rdata=0x1234; sram_wen=0 only in the write issue cycle.
- WR_TURN=1: A read accepted, B write valid the next cycle -> B write stalls exactly 1 cycle (b_ready=0), then issues; with WR_TURN=0 there is no stall.
- rstn pulsed low while 1 read is in flight -> no rvalid ever appears for it; all outputs at reset values asynchronously; idle=1 after release.
- RD_LAT=3: single B read -> b_rvalid exactly 4 cycles after the accept edge; idle=0 throughout, then 1.

Source files
------------

// File: rtl/sram_arb.sv
// Round-robin two-port arbiter and access sequencer for a single-port SRAM macro.
// Read data is steered back to its requester through a fixed-latency owner-tag pipeline.
module sram_arb #(
    parameter int unsigned AW      = 19,
    parameter int unsigned DW      = 16,
    parameter int unsigned RD_LAT  = 1,
    parameter int unsigned WR_TURN = 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          a_valid,
    output logic          a_ready,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_rvalid,
    output logic [DW-1:0] a_rdata,
    input  logic          b_valid,
    output logic          b_ready,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_rvalid,
    output logic [DW-1:0] b_rdata,
    output logic          sram_csn,
    output logic          sram_wen,
    output logic [AW-1:0] sram_a,
    output logic [DW-1:0] sram_din,
    input  logic [DW-1:0] sram_dout,
    output logic          idle
);

    typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_e;

    logic [1:0]      turn_q, turn_d;
    port_e           prio_q, prio_d;
    logic            csn_q, csn_d;
    logic            wen_q, wen_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   din_q, din_d;
    logic [RD_LAT:0] pv_q, pv_d;
    logic [RD_LAT:0] ptag_q, ptag_d;
    logic            a_rvalid_q, a_rvalid_d;
    logic            b_rvalid_q, b_rvalid_d;
    logic [DW-1:0]   a_rdata_q, a_rdata_d;
    logic [DW-1:0]   b_rdata_q, b_rdata_d;

    logic            a_elig, b_elig, grant_a, grant_b, accept, is_read;
    logic            sel_we;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;

    // prio_q names the port that wins when both are eligible.
    always_comb begin
        a_elig    = a_valid && !(a_we && (turn_q != '0));
        b_elig    = b_valid && !(b_we && (turn_q != '0));
        grant_a   = a_elig && (!b_elig || (prio_q == PORT_A));
        grant_b   = b_elig && !grant_a;
        accept    = grant_a || grant_b;
        sel_we    = grant_b ? b_we    : a_we;
        sel_addr  = grant_b ? b_addr  : a_addr;
        sel_wdata = grant_b ? b_wdata : a_wdata;
        is_read   = accept && !sel_we;
    end

    always_comb begin
        turn_d = turn_q;
        if (is_read) begin
            turn_d = 2'(WR_TURN);
        end else if (turn_q != '0) begin
            turn_d = turn_q - 2'd1;
        end

        prio_d = prio_q;
        if (grant_a) begin
            prio_d = PORT_B;
        end else if (grant_b) begin
            prio_d = PORT_A;
        end

        csn_d  = !accept;
        wen_d  = !(accept && sel_we);
        addr_d = accept ? sel_addr  : addr_q;
        din_d  = accept ? sel_wdata : din_q;

        // Tag bit 1 marks a read owned by port B.
        pv_d   = {pv_q[RD_LAT-1:0], is_read};
        ptag_d = {ptag_q[RD_LAT-1:0], grant_b};

        a_rvalid_d = pv_q[RD_LAT] && !ptag_q[RD_LAT];
        b_rvalid_d = pv_q[RD_LAT] &&  ptag_q[RD_LAT];
        a_rdata_d  = a_rvalid_d ? sram_dout : a_rdata_q;
        b_rdata_d  = b_rvalid_d ? sram_dout : b_rdata_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            turn_q     <= '0;
            prio_q     <= PORT_A;
            csn_q      <= 1'b1;
            wen_q      <= 1'b1;
            addr_q     <= '0;
            din_q      <= '0;
            pv_q       <= '0;
            ptag_q     <= '0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            turn_q     <= turn_d;
            prio_q     <= prio_d;
            csn_q      <= csn_d;
            wen_q      <= wen_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            pv_q       <= pv_d;
            ptag_q     <= ptag_d;
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
        end
    end

    assign a_ready  = grant_a;
    assign b_ready  = grant_b;
    assign a_rvalid = a_rvalid_q;
    assign b_rvalid = b_rvalid_q;
    assign a_rdata  = a_rdata_q;
    assign b_rdata  = b_rdata_q;
    assign sram_csn = csn_q;
    assign sram_wen = wen_q;
    assign sram_a   = addr_q;
    assign sram_din = din_q;
    assign idle     = (pv_q == '0) && csn_q;

endmodule

// File: tb/tb_sram_arb.sv
// Bench for sram_arb: three parameterisations share one stimulus stream, each with its own
// SRAM model; one instance at a time is scored against a transaction-level reference.
module tb_sram_arb;
    localparam int AW = 19;
    localparam int DW = 16;
    localparam int NI = 3;
    localparam int LATS  [NI] = '{1, 3, 4};
    localparam int TURNS [NI] = '{1, 0, 2};
    localparam logic [AW-1:0] PA [3] = '{19'h00001, 19'h00005, 19'h00043};
    localparam logic [DW-1:0] PD [3] = '{16'hBEEF, 16'hA5A5, 16'h4343};

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    logic          a_valid = 1'b0, a_we = 1'b0, b_valid = 1'b0, b_we = 1'b0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [DW-1:0] a_wdata = '0, b_wdata = '0;
    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [DW-1:0] pre_data = '0;

    logic [NI-1:0] a_ready_w, b_ready_w, a_rvalid_w, b_rvalid_w, csn_w, wen_w, idle_w;
    logic [AW-1:0] sa_w [NI];
    logic [DW-1:0] din_w [NI];
    logic [DW-1:0] a_rdata_w [NI];
    logic [DW-1:0] b_rdata_w [NI];

    int checks = 0;
    int failures = 0;
    int sel = 0;
    int edge_n = 0;
    int last_rd = -100;
    bit pref_b = 1'b0;
    logic          exp_csn, exp_wen;
    logic [AW-1:0] exp_a;
    logic [DW-1:0] exp_din;
    logic [DW-1:0] exp_rd [2];

    typedef struct { int due; bit port; logic [DW-1:0] data; } resp_t;
    resp_t rq[$];
    logic [DW-1:0] ref_mem [int];

    typedef struct { bit av; bit awe; bit bv; bit bwe; bit ar; bit br; } vec_t;
    vec_t tbl [11];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int L = LATS[g];
        bit [DW-1:0] mem [0:(1<<AW)-1];
        bit [DW-1:0] dpipe [0:L-1];

        sram_arb #(.AW(AW), .DW(DW), .RD_LAT(L), .WR_TURN(TURNS[g])) u_dut (
            .clk(clk), .rstn(rstn),
            .a_valid(a_valid), .a_ready(a_ready_w[g]), .a_we(a_we), .a_addr(a_addr),
            .a_wdata(a_wdata), .a_rvalid(a_rvalid_w[g]), .a_rdata(a_rdata_w[g]),
            .b_valid(b_valid), .b_ready(b_ready_w[g]), .b_we(b_we), .b_addr(b_addr),
            .b_wdata(b_wdata), .b_rvalid(b_rvalid_w[g]), .b_rdata(b_rdata_w[g]),
            .sram_csn(csn_w[g]), .sram_wen(wen_w[g]), .sram_a(sa_w[g]), .sram_din(din_w[g]),
            .sram_dout(dpipe[L-1]), .idle(idle_w[g])
        );

        // SRAM: samples pins on the edge after issue, data appears L edges later.
        always @(posedge clk) begin
            if (pre_we) begin
                mem[pre_addr] <= pre_data;
            end else if (!csn_w[g]) begin
                if (!wen_w[g]) mem[sa_w[g]] <= din_w[g];
                else           dpipe[0] <= mem[sa_w[g]];
            end
            for (int i = 1; i < L; i++) dpipe[i] <= dpipe[i-1];
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not finish, edge=%0d required finish before limit", edge_n);
        $fatal(1, "watchdog expired");
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst=%0d edge=%0d: got %b, required %b", name, sel, edge_n, act, exp);
        end
    endtask

    task automatic chkv(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst=%0d edge=%0d: got 0x%0h, required 0x%0h", name, sel, edge_n, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rm(input logic [AW-1:0] ad);
        int k;
        k = int'(ad);
        return ref_mem.exists(k) ? ref_mem[k] : '0;
    endfunction

    task automatic model_reset();
        rq.delete();
        pref_b    = 1'b0;
        last_rd   = -100;
        exp_csn   = 1'b1;
        exp_wen   = 1'b1;
        exp_a     = '0;
        exp_din   = '0;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
    endtask

    // Called just after a falling edge with inputs driven; returns just after the next falling edge.
    task automatic tick(output bit dra, output bit drb, output bit ga, output bit gb);
        bit ea, eb, acc, port, we, eva, evb;
        logic [AW-1:0] ad;
        logic [DW-1:0] wd;
        resp_t r;
        int lat_v, turn_v;
        lat_v  = LATS[sel];
        turn_v = TURNS[sel];
        #1;
        ea  = a_valid && !(a_we && ((edge_n + 1 - last_rd) <= turn_v));
        eb  = b_valid && !(b_we && ((edge_n + 1 - last_rd) <= turn_v));
        ga  = ea && (!eb || !pref_b);
        gb  = eb && !ga;
        dra = a_ready_w[sel];
        drb = b_ready_w[sel];
        chk1("a_ready", dra, ga);
        chk1("b_ready", drb, gb);
        @(posedge clk);
        edge_n++;
        acc  = ga || gb;
        port = gb;
        we   = port ? b_we    : a_we;
        ad   = port ? b_addr  : a_addr;
        wd   = port ? b_wdata : a_wdata;
        if (acc) begin
            exp_csn = 1'b0;
            exp_wen = !we;
            exp_a   = ad;
            exp_din = wd;
            pref_b  = !port;
            if (we) begin
                ref_mem[int'(ad)] = wd;
            end else begin
                rq.push_back('{edge_n + 1 + lat_v, port, rm(ad)});
                last_rd = edge_n;
            end
        end else begin
            exp_csn = 1'b1;
            exp_wen = 1'b1;
        end
        eva = 1'b0;
        evb = 1'b0;
        if (rq.size() > 0 && rq[0].due == edge_n) begin
            r = rq.pop_front();
            exp_rd[r.port] = r.data;
            if (r.port) evb = 1'b1; else eva = 1'b1;
        end
        #1;
        chk1("sram_csn", csn_w[sel], exp_csn);
        chk1("sram_wen", wen_w[sel], exp_wen);
        chkv("sram_a", 32'(sa_w[sel]), 32'(exp_a));
        chkv("sram_din", 32'(din_w[sel]), 32'(exp_din));
        chk1("a_rvalid", a_rvalid_w[sel], eva);
        chk1("b_rvalid", b_rvalid_w[sel], evb);
        chkv("a_rdata", 32'(a_rdata_w[sel]), 32'(exp_rd[0]));
        chkv("b_rdata", 32'(b_rdata_w[sel]), 32'(exp_rd[1]));
        chk1("idle", idle_w[sel], !acc && (rq.size() == 0));
        @(negedge clk);
    endtask

    task automatic do_reset();
        a_valid = 1'b0;
        b_valid = 1'b0;
        rstn    = 1'b0;
        #1;
        chk1("rst_csn", csn_w[sel], 1'b1);
        chk1("rst_wen", wen_w[sel], 1'b1);
        chkv("rst_sram_a", 32'(sa_w[sel]), 32'h0);
        chkv("rst_din", 32'(din_w[sel]), 32'h0);
        chk1("rst_a_rvalid", a_rvalid_w[sel], 1'b0);
        chk1("rst_b_rvalid", b_rvalid_w[sel], 1'b0);
        chkv("rst_a_rdata", 32'(a_rdata_w[sel]), 32'h0);
        chkv("rst_b_rdata", 32'(b_rdata_w[sel]), 32'h0);
        chk1("rst_idle", idle_w[sel], 1'b1);
        pre_we = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pre_addr = PA[i];
            pre_data = PD[i];
            @(posedge clk);
            #1;
            ref_mem[int'(PA[i])] = PD[i];
        end
        pre_we = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        model_reset();
    endtask

    task automatic rand_phase(input int n, input int base);
        bit dra, drb, ga, gb;
        ga = 1'b0;
        gb = 1'b0;
        for (int c = 0; c < n; c++) begin
            if (!a_valid || ga) begin
                a_valid = ($urandom_range(0, 99) < 65);
                a_we    = 1'($urandom_range(0, 1));
                a_addr  = AW'(base + int'($urandom_range(0, 15)));
                a_wdata = DW'($urandom);
            end
            if (!b_valid || gb) begin
                b_valid = ($urandom_range(0, 99) < 65);
                b_we    = 1'($urandom_range(0, 1));
                b_addr  = AW'(base + int'($urandom_range(0, 15)));
                b_wdata = DW'($urandom);
            end
            tick(dra, drb, ga, gb);
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        for (int c = 0; c < 6; c++) tick(dra, drb, ga, gb);
    endtask

    initial begin
        bit dra, drb, ga, gb;
        tbl[0]  = '{1, 0, 1, 0, 1, 0};
        tbl[1]  = '{1, 0, 1, 0, 0, 1};
        tbl[2]  = '{1, 1, 1, 0, 0, 1};
        tbl[3]  = '{1, 1, 0, 0, 0, 0};
        tbl[4]  = '{1, 1, 1, 1, 1, 0};
        tbl[5]  = '{1, 1, 1, 1, 0, 1};
        tbl[6]  = '{0, 0, 0, 0, 0, 0};
        tbl[7]  = '{0, 0, 1, 0, 0, 1};
        tbl[8]  = '{1, 0, 1, 1, 1, 0};
        tbl[9]  = '{0, 0, 1, 1, 0, 0};
        tbl[10] = '{0, 0, 1, 1, 0, 1};

        @(negedge clk);
        sel = 0;
        do_reset();

        // Arbitration table on the WR_TURN=1 instance, starting from reset priority.
        a_addr = 19'h00300; a_wdata = 16'h3A3A;
        b_addr = 19'h00301; b_wdata = 16'h3B3B;
        for (int i = 0; i < 11; i++) begin
            a_valid = tbl[i].av; a_we = tbl[i].awe;
            b_valid = tbl[i].bv; b_we = tbl[i].bwe;
            tick(dra, drb, ga, gb);
            chk1("tbl_a_ready", dra, tbl[i].ar);
            chk1("tbl_b_ready", drb, tbl[i].br);
            chk1("tbl_csn", csn_w[0], !(tbl[i].ar || tbl[i].br));
        end
        a_valid = 1'b0; b_valid = 1'b0;
        tick(dra, drb, ga, gb);

        // Single A read of preloaded 0xBEEF.
        a_valid = 1'b1; a_we = 1'b0; a_addr = 19'h00001;
        tick(dra, drb, ga, gb);
        chk1("s1_ready", dra, 1'b1);
        chk1("s1_csn", csn_w[0], 1'b0);
        chkv("s1_sram_a", 32'(sa_w[0]), 32'h1);
        a_valid = 1'b0;
        tick(dra, drb, ga, gb);
        chk1("s1_rvalid_early", a_rvalid_w[0], 1'b0);
        chk1("s1_csn_off", csn_w[0], 1'b1);
        tick(dra, drb, ga, gb);
        chk1("s1_rvalid", a_rvalid_w[0], 1'b1);
        chkv("s1_rdata", 32'(a_rdata_w[0]), 32'hBEEF);
        chk1("s1_b_rvalid", b_rvalid_w[0], 1'b0);
        tick(dra, drb, ga, gb);
        chk1("s1_rvalid_end", a_rvalid_w[0], 1'b0);
        chkv("s1_rdata_hold", 32'(a_rdata_w[0]), 32'hBEEF);

        // Both ports hold reads: strict alternation from reset priority.
        do_reset();
        a_valid = 1'b1; a_we = 1'b0; a_addr = 19'h00005;
        b_valid = 1'b1; b_we = 1'b0; b_addr = 19'h00043;
        for (int i = 0; i < 6; i++) begin
            tick(dra, drb, ga, gb);
            chk1("s2_a_ready", dra, (i % 2) == 0);
            chk1("s2_b_ready", drb, (i % 2) == 1);
            chk1("s2_csn", csn_w[0], 1'b0);
        end
        a_valid = 1'b0; b_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick(dra, drb, ga, gb);
        chkv("s2_a_rdata", 32'(a_rdata_w[0]), 32'hA5A5);
        chkv("s2_b_rdata", 32'(b_rdata_w[0]), 32'h4343);

        // A write then B read of the same word.
        a_valid = 1'b1; a_we = 1'b1; a_addr = 19'h00005; a_wdata = 16'h1234;
        tick(dra, drb, ga, gb);
        chk1("s3_wen_write", wen_w[0], 1'b0);
        a_valid = 1'b0;
        b_valid = 1'b1; b_we = 1'b0; b_addr = 19'h00005;
        tick(dra, drb, ga, gb);
        chk1("s3_wen_read", wen_w[0], 1'b1);
        b_valid = 1'b0;
        tick(dra, drb, ga, gb);
        tick(dra, drb, ga, gb);
        chk1("s3_b_rvalid", b_rvalid_w[0], 1'b1);
        chkv("s3_b_rdata", 32'(b_rdata_w[0]), 32'h1234);

        // Read followed by a write: one stall cycle with WR_TURN=1, none with WR_TURN=0.
        a_valid = 1'b1; a_we = 1'b0; a_addr = 19'h00043;
        tick(dra, drb, ga, gb);
        a_valid = 1'b0;
        b_valid = 1'b1; b_we = 1'b1; b_addr = 19'h00100; b_wdata = 16'h7777;
        #1;
        chk1("s4_turn1_stall", b_ready_w[0], 1'b0);
        chk1("s4_turn0_nostall", b_ready_w[1], 1'b1);
        tick(dra, drb, ga, gb);
        chk1("s4_stall_ready", drb, 1'b0);
        tick(dra, drb, ga, gb);
        chk1("s4_after_ready", drb, 1'b1);
        chk1("s4_wen", wen_w[0], 1'b0);
        b_valid = 1'b0;
        tick(dra, drb, ga, gb);
        tick(dra, drb, ga, gb);

        // Reset while a read is in flight: the read must vanish.
        a_valid = 1'b1; a_we = 1'b0; a_addr = 19'h00001;
        tick(dra, drb, ga, gb);
        chk1("s5_busy", idle_w[0], 1'b0);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick(dra, drb, ga, gb);
            chk1("s5_no_rvalid", a_rvalid_w[0], 1'b0);
            chk1("s5_idle", idle_w[0], 1'b1);
        end

        // RD_LAT=3 instance: single B read.
        sel = 1;
        b_valid = 1'b1; b_we = 1'b0; b_addr = 19'h00043;
        tick(dra, drb, ga, gb);
        chk1("s6_ready", drb, 1'b1);
        chk1("s6_idle0", idle_w[1], 1'b0);
        b_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick(dra, drb, ga, gb);
            chk1("s6_rvalid", b_rvalid_w[1], k == 4);
            chk1("s6_idle", idle_w[1], k == 4);
        end
        chkv("s6_rdata", 32'(b_rdata_w[1]), 32'h4343);

        rand_phase(300, 32'h200);
        sel = 2;
        do_reset();
        rand_phase(300, 32'h210);
        sel = 0;
        do_reset();
        rand_phase(400, 32'h220);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
